// File: rtl/rr_arb_mux_pkg.sv
// Shared constants and helpers for the rr_arb_mux selector/arbiter.
package rr_arb_mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    // Index width that never collapses to zero bits, even for tiny channel counts.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arb_mux_if.sv
// Producer/consumer bundle for rr_arb_mux; in_last exists only when
// RR_ARB_MUX_PKT_LOCK_EN is defined.
interface rr_arb_mux_if
    import rr_arb_mux_pkg::*;
#(
    parameter int BUS_SIZE = 8,
    parameter int NUM_IN   = 4
) ();

    localparam int SEL_W = clog2_min1(NUM_IN);

    logic [NUM_IN*BUS_SIZE-1:0] in_data;
    logic [NUM_IN-1:0]          in_valid;
    logic [NUM_IN-1:0]          in_ready;
    logic                       mode;
    logic [SEL_W-1:0]           sel;
    logic [BUS_SIZE-1:0]        out_data;
    logic [SEL_W-1:0]           out_src;
    logic                       out_valid;
    logic                       out_ready;

`ifdef RR_ARB_MUX_PKT_LOCK_EN
    logic [NUM_IN-1:0]          in_last;

    modport slave (
        input  in_data, in_valid, in_last, mode, sel, out_ready,
        output in_ready, out_data, out_src, out_valid
    );
    modport master (
        output in_data, in_valid, in_last, mode, sel, out_ready,
        input  in_ready, out_data, out_src, out_valid
    );
`else
    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_src, out_valid
    );
    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_src, out_valid
    );
`endif

endinterface

// File: rtl/rr_arb_mux_rr_pick.sv
// Rotating-priority finder: first set req bit strictly after base, wrapping
// modulo NUM_IN (base itself is checked last).
module rr_pick #(
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  base,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              gnt_valid
);

    int idx;

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NUM_IN; k++) begin
            idx = (int'(base) + k) % NUM_IN;
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel selector with registered output: external select or round-robin.
// Define RR_ARB_MUX_PKT_LOCK_EN to hold the grant across multi-beat packets.
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter int BUS_SIZE = 8,
    parameter int NUM_IN   = 4
) (
    input logic          clk,
    input logic          rst,
    rr_arb_mux_if.slave  bus
);

    localparam int SEL_W = clog2_min1(NUM_IN);

    logic             ld;
    logic [SEL_W-1:0] last_grant;
    logic [SEL_W-1:0] cand;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_valid;
    logic [SEL_W-1:0] grant_idx;
    logic             grant_valid;

    // Single-entry output stage: refill whenever empty or being drained this cycle.
    assign ld   = !bus.out_valid || bus.out_ready;
    assign cand = (int'(bus.sel) >= NUM_IN) ? '0 : bus.sel;

    rr_pick #(
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_rr_pick (
        .req       (bus.in_valid),
        .base      (last_grant),
        .gnt_idx   (rr_idx),
        .gnt_valid (rr_valid)
    );

`ifdef RR_ARB_MUX_PKT_LOCK_EN
    logic             locked;
    logic [SEL_W-1:0] lock_idx;
`endif

    always_comb begin
        grant_idx   = cand;
        grant_valid = bus.in_valid[cand];
        if (bus.mode == MODE_RR) begin
            grant_idx   = rr_idx;
            grant_valid = rr_valid;
        end
`ifdef RR_ARB_MUX_PKT_LOCK_EN
        // An open packet overrides both select and round-robin order.
        if (locked) begin
            grant_idx   = lock_idx;
            grant_valid = bus.in_valid[lock_idx];
        end
`endif
    end

    always_comb begin
        bus.in_ready = '0;
        if (ld && grant_valid)
            bus.in_ready[grant_idx] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_src   <= '0;
            last_grant    <= SEL_W'(NUM_IN - 1);
        end else if (ld) begin
            if (grant_valid) begin
                bus.out_data  <= bus.in_data[int'(grant_idx)*BUS_SIZE +: BUS_SIZE];
                bus.out_src   <= grant_idx;
                bus.out_valid <= 1'b1;
                last_grant    <= grant_idx;
            end else begin
                bus.out_valid <= 1'b0;
            end
        end
    end

`ifdef RR_ARB_MUX_PKT_LOCK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked   <= 1'b0;
            lock_idx <= '0;
        end else if (ld && grant_valid) begin
            locked   <= !bus.in_last[grant_idx];
            lock_idx <= grant_idx;
        end
    end
`endif

endmodule
